// File: rtl/mac_rx_frame_fifo.sv
// Receive frame buffer behind the MAC: stores words of the current frame, commits
// them only on a good verdict, and streams committed frames out as ready/valid.
module mac_rx_frame_fifo #(
  parameter int ADDR_W = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] rx_data,
  input  logic [7:0]  rx_data_valid,
  input  logic        rx_good_frame,
  input  logic        rx_bad_frame,
  output logic [63:0] m_data,
  output logic [7:0]  m_keep,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] good_count,
  output logic [31:0] bad_count,
  output logic [31:0] drop_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef logic [ADDR_W:0] ptr_t;
  typedef logic [72:0]     entry_t;   // {last, keep[7:0], data[63:0]}
  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_RECV, ST_DROP} state_t;

  entry_t mem [DEPTH];

  state_t              state_q, state_d;
  ptr_t                wr_ptr_q, wr_ptr_d;
  ptr_t                wr_commit_q, wr_commit_d;
  ptr_t                rd_ptr_q, rd_ptr_d;
  logic [31:0]         good_q, good_d;
  logic [31:0]         bad_q, bad_d;
  logic [31:0]         drop_q, drop_d;
  logic [63:0]         shadow_data_q, shadow_data_d;
  logic [7:0]          shadow_keep_q, shadow_keep_d;
  logic                r1_valid_q, r1_valid_d;
  logic                m_valid_q, m_valid_d;
  entry_t              out_word_q, out_word_d;
  entry_t              rd_word_q;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  entry_t              mem_wdata;
  logic                has_data, end_pulse, full, do_resolve;
  ptr_t                wr_next, resolve_ptr;
  logic                avail, out_take, rd_issue;

  assign has_data  = |rx_data_valid;
  assign end_pulse = rx_good_frame | rx_bad_frame;
  assign full      = (wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH);
  assign wr_next   = wr_ptr_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    wr_commit_d   = wr_commit_q;
    good_d        = good_q;
    bad_d         = bad_q;
    drop_d        = drop_q;
    shadow_data_d = shadow_data_q;
    shadow_keep_d = shadow_keep_q;
    mem_we        = 1'b0;
    mem_waddr     = wr_ptr_q[ADDR_W-1:0];
    mem_wdata     = {end_pulse, rx_data_valid, rx_data};
    do_resolve    = 1'b0;
    resolve_ptr   = wr_ptr_q;

    case (state_q)
      ST_SYNC: begin
        if (end_pulse || !has_data) state_d = ST_IDLE;
      end
      ST_IDLE, ST_RECV: begin
        if (has_data) begin
          if (full) begin
            if (end_pulse) begin
              drop_d   = drop_q + 32'd1;
              wr_ptr_d = wr_commit_q;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            mem_we        = 1'b1;
            shadow_data_d = rx_data;
            shadow_keep_d = rx_data_valid;
            resolve_ptr   = wr_next;
            if (end_pulse) begin
              do_resolve = 1'b1;
            end else begin
              wr_ptr_d = wr_next;
              state_d  = ST_RECV;
            end
          end
        end else if (end_pulse) begin
          if (state_q == ST_IDLE) begin
            drop_d = drop_q + 32'd1;
          end else begin
            // Pulse arrived after the final word: rewrite that word with last set,
            // using the shadow copy instead of a read-modify-write of the RAM.
            mem_we     = 1'b1;
            mem_waddr  = wr_ptr_q[ADDR_W-1:0] - 1'b1;
            mem_wdata  = {1'b1, shadow_keep_q, shadow_data_q};
            do_resolve = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (end_pulse) begin
          drop_d   = drop_q + 32'd1;
          wr_ptr_d = wr_commit_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (do_resolve) begin
      state_d = ST_IDLE;
      if (rx_bad_frame) begin
        wr_ptr_d = wr_commit_q;
        bad_d    = bad_q + 32'd1;
      end else begin
        wr_ptr_d    = resolve_ptr;
        wr_commit_d = resolve_ptr;
        good_d      = good_q + 32'd1;
      end
    end
  end

  // Read pipeline: RAM output stage feeding a single output register.
  always_comb begin
    avail      = rd_ptr_q != wr_commit_q;
    out_take   = !m_valid_q || m_ready;
    rd_issue   = avail && (!r1_valid_q || out_take);
    rd_ptr_d   = rd_issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    r1_valid_d = rd_issue || (r1_valid_q && !out_take);
    m_valid_d  = out_take ? r1_valid_q : m_valid_q;
    out_word_d = (out_take && r1_valid_q) ? rd_word_q : out_word_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_issue) rd_word_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SYNC;
      wr_ptr_q      <= '0;
      wr_commit_q   <= '0;
      rd_ptr_q      <= '0;
      good_q        <= '0;
      bad_q         <= '0;
      drop_q        <= '0;
      shadow_data_q <= '0;
      shadow_keep_q <= '0;
      r1_valid_q    <= 1'b0;
      m_valid_q     <= 1'b0;
      out_word_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_commit_q   <= wr_commit_d;
      rd_ptr_q      <= rd_ptr_d;
      good_q        <= good_d;
      bad_q         <= bad_d;
      drop_q        <= drop_d;
      shadow_data_q <= shadow_data_d;
      shadow_keep_q <= shadow_keep_d;
      r1_valid_q    <= r1_valid_d;
      m_valid_q     <= m_valid_d;
      out_word_q    <= out_word_d;
    end
  end

  assign m_data     = out_word_q[63:0];
  assign m_keep     = out_word_q[71:64];
  assign m_last     = out_word_q[72];
  assign m_valid    = m_valid_q;
  assign good_count = good_q;
  assign bad_count  = bad_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_mac_rx_frame_fifo.sv
// Directed bench for mac_rx_frame_fifo: a default-depth instance and a depth-8
// instance share the MAC-side stimulus; each is held in reset while unused.
module tb_mac_rx_frame_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b;
  logic [63:0] rx_data;
  logic [7:0]  rx_dv;
  logic        rx_good, rx_bad, m_ready;

  logic [63:0] a_data, b_data;
  logic [7:0]  a_keep, b_keep;
  logic        a_last, b_last, a_valid, b_valid;
  logic [31:0] a_good, a_bad, a_drop, b_good, b_bad, b_drop;

  mac_rx_frame_fifo #(.ADDR_W(9)) dut_a (
    .clk(clk), .reset(reset_a), .rx_data(rx_data), .rx_data_valid(rx_dv),
    .rx_good_frame(rx_good), .rx_bad_frame(rx_bad),
    .m_data(a_data), .m_keep(a_keep), .m_last(a_last), .m_valid(a_valid),
    .m_ready(m_ready), .good_count(a_good), .bad_count(a_bad), .drop_count(a_drop));

  mac_rx_frame_fifo #(.ADDR_W(3)) dut_b (
    .clk(clk), .reset(reset_b), .rx_data(rx_data), .rx_data_valid(rx_dv),
    .rx_good_frame(rx_good), .rx_bad_frame(rx_bad),
    .m_data(b_data), .m_keep(b_keep), .m_last(b_last), .m_valid(b_valid),
    .m_ready(m_ready), .good_count(b_good), .bad_count(b_bad), .drop_count(b_drop));

  int          total_n = 0;
  int          bad_n   = 0;
  bit          rnd_ready = 1'b0;
  logic [72:0] exp_q[$];
  logic [72:0] got_a[$];
  logic [72:0] got_b[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_n++;
    assert (got === exp) else begin
      bad_n++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [73:0] a_prev;
  logic [73:0] a_cur;
  bit          a_stall = 1'b0;
  always @(negedge clk) begin
    a_cur = {a_valid, a_last, a_keep, a_data};
    if (a_stall && !reset_a) chk("hold_stable", a_cur, a_prev);
    if (a_valid && m_ready) got_a.push_back({a_last, a_keep, a_data});
    if (b_valid && m_ready) got_b.push_back({b_last, b_keep, b_data});
    a_stall = a_valid && !m_ready;
    a_prev  = a_cur;
  end

  task automatic cyc(input logic [63:0] d, input logic [7:0] k, input logic g, input logic b);
    rx_data = d; rx_dv = k; rx_good = g; rx_bad = b;
    if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset_a();
    reset_a = 1'b1; idle(1);
    reset_a = 1'b0; idle(1);
    exp_q.delete(); got_a.delete(); got_b.delete();
  endtask

  // verdict: 0 good, 1 bad, 2 both pulses; sep puts the pulse on a following empty cycle
  task automatic send_frame(input int n, input int verdict, input bit sep);
    logic [63:0] d;
    logic [7:0]  k, kl, ff;
    logic        g, b, end_now;
    int          nb;
    g  = (verdict != 1);
    b  = (verdict != 0);
    ff = 8'hFF;
    nb = $urandom_range(1, 8);
    kl = ff >> (8 - nb);
    for (int i = 0; i < n; i++) begin
      d = {$urandom(), $urandom()};
      k = (i == n - 1) ? kl : 8'hFF;
      for (int j = 0; j < 8; j++) if (!k[j]) d[j*8 +: 8] = 8'h00;
      end_now = (i == n - 1) && !sep;
      cyc(d, k, end_now & g, end_now & b);
      if (verdict == 0) exp_q.push_back({(i == n - 1), k, d});
    end
    if (sep) cyc('0, '0, g, b);
  endtask

  task automatic wait_stream(input bit use_b, input int budget, input string tag);
    int n = 0;
    while ((use_b ? got_b.size() : got_a.size()) < exp_q.size() && n < budget) begin
      idle(1);
      n++;
    end
    chk({tag, "_arrived"}, (use_b ? got_b.size() : got_a.size()) >= exp_q.size(), 1);
  endtask

  task automatic check_stream(input bit use_b, input string tag);
    int n_got = use_b ? got_b.size() : got_a.size();
    chk({tag, "_count"}, n_got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_got; i++)
      chk({tag, "_word"}, use_b ? got_b[i] : got_a[i], exp_q[i]);
    exp_q.delete(); got_a.delete(); got_b.delete();
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    rx_data = '0; rx_dv = '0; rx_good = 1'b0; rx_bad = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;

    // Good frame with exact latency check
    do_reset_a();
    chk("rst_good", a_good, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_data", a_data, 0);
    cyc(64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    cyc(64'h0f0e0d0c0b0a0908, 8'hFF, 1'b0, 1'b0);
    cyc(64'h0000000013121110, 8'h0F, 1'b1, 1'b0);
    exp_q.push_back({1'b0, 8'hFF, 64'h0706050403020100});
    exp_q.push_back({1'b0, 8'hFF, 64'h0f0e0d0c0b0a0908});
    exp_q.push_back({1'b1, 8'h0F, 64'h0000000013121110});
    chk("t1_good_count", a_good, 1);
    chk("t1_valid_n0", a_valid, 0);
    idle(1);
    chk("t1_valid_n1", a_valid, 0);
    idle(1);
    chk("t1_valid_n2", a_valid, 1);
    chk("t1_first_data", a_data, 64'h0706050403020100);
    chk("t1_first_last", a_last, 0);
    wait_stream(0, 10, "t1");
    idle(3);
    check_stream(0, "t1");

    // Bad frame then good frame
    do_reset_a();
    send_frame(4, 1, 0);
    send_frame(2, 0, 0);
    wait_stream(0, 20, "t2");
    idle(5);
    check_stream(0, "t2");
    chk("t2_bad_count", a_bad, 1);
    chk("t2_good_count", a_good, 1);

    // Overflow on the depth-8 instance
    reset_a = 1'b1;
    idle(1);
    reset_b = 1'b0;
    idle(1);
    m_ready = 1'b0;
    send_frame(10, 0, 0);
    exp_q.delete();
    idle(4);
    chk("t3_drop_count", b_drop, 1);
    chk("t3_good_count", b_good, 0);
    chk("t3_valid", b_valid, 0);
    chk("t3_no_output", got_b.size(), 0);
    m_ready = 1'b1;
    send_frame(2, 0, 0);
    wait_stream(1, 20, "t3");
    idle(3);
    check_stream(1, "t3");
    reset_b = 1'b1;

    // Backpressure over 20 random frames
    do_reset_a();
    rnd_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      send_frame($urandom_range(1, 20), 0, ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 2));
    end
    wait_stream(0, 3000, "t4");
    rnd_ready = 1'b0;
    m_ready = 1'b1;
    idle(4);
    check_stream(0, "t4");
    chk("t4_good_count", a_good, 20);
    chk("t4_drop_count", a_drop, 0);

    // Mid-frame reset
    do_reset_a();
    cyc(64'hA1, 8'hFF, 1'b0, 1'b0);
    cyc(64'hA2, 8'hFF, 1'b0, 1'b0);
    cyc(64'hA3, 8'hFF, 1'b0, 1'b0);
    reset_a = 1'b1;
    cyc(64'hA4, 8'hFF, 1'b0, 1'b0);
    reset_a = 1'b0;
    cyc(64'hA5, 8'hFF, 1'b0, 1'b0);
    cyc(64'hA6, 8'hFF, 1'b1, 1'b0);
    exp_q.delete(); got_a.delete();
    send_frame(2, 0, 0);
    wait_stream(0, 20, "t5");
    idle(4);
    check_stream(0, "t5");
    chk("t5_good_count", a_good, 1);
    chk("t5_bad_count", a_bad, 0);
    chk("t5_drop_count", a_drop, 0);

    // Edge pulses
    do_reset_a();
    cyc('0, '0, 1'b1, 1'b0);
    chk("t6_lone_drop", a_drop, 1);
    send_frame(1, 2, 0);
    idle(6);
    chk("t6_both_bad", a_bad, 1);
    chk("t6_both_good", a_good, 0);
    chk("t6_valid", a_valid, 0);
    check_stream(0, "t6");

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/mac_rx_frame_fifo.md
# mac_rx_frame_fifo

Receive-side frame buffer directly downstream of `oc_mac`. It consumes the MAC's per-cycle 64-bit word stream (`rx_data`, `rx_data_valid`) and its end-of-frame verdict pulses (`rx_good_frame`, `rx_bad_frame`). Only frames ending in a good verdict are committed. Committed frames are presented to the parser as a ready/valid stream; bad, overflowed and empty frames are discarded by rewinding the write pointer. Counters report good, bad and dropped frames.

## Interface
- `ADDR_W`, default 9: buffer depth is 2^ADDR_W words; each entry holds data[63:0], keep[7:0] and last.
- `clk`  in  1  sole clock, same domain as the MAC `rx_clk`.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  64  MAC word; byte 0 is bits 7:0.
- `rx_data_valid`  in  8  byte-valid mask, contiguous from bit 0. Nonzero every cycle inside a frame; all zero between frames.
- `rx_good_frame`  in  1  one-cycle pulse: the current frame ended and passed the FCS check.
- `rx_bad_frame`  in  1  one-cycle pulse: the current frame ended and is bad.
- `m_data`  out  64  output word.
- `m_keep`  out  8  output byte mask.
- `m_last`  out  1  marks the final word of a frame.
- `m_valid`  out  1  output word is valid.
- `m_ready`  in  1  downstream accepts the word.
- `good_count`  out  32  committed frames; wraps modulo 2^32.
- `bad_count`  out  32  frames discarded on `rx_bad_frame`; wraps.
- `drop_count`  out  32  frames discarded on overflow or zero length; wraps.

## Operation
- **Pointers.**
  - `wr_ptr`, `wr_commit` and `rd_ptr` are ADDR_W+1 bits wide.
  - The buffer is full when `wr_ptr - rd_ptr == 2^ADDR_W`.
  - Committed data is available when `rd_ptr != wr_commit`.
- **Write state machine.**
  - SYNC: state after reset. Ignores all input. Moves to IDLE on any cycle with `rx_data_valid == 0` and no end pulse. Also moves to IDLE on an end pulse; that frame is discarded and no counter changes.
  - IDLE:
    - On `rx_data_valid != 0`: write the word and go to RECV.
    - If an end pulse arrives in the same cycle, the one-word frame is resolved immediately and the state stays IDLE.
    - An end pulse with no data is a zero-length frame: `drop_count++`.
  - RECV:
    - Write each word with `rx_data_valid != 0`.
    - A word present in the end-pulse cycle belongs to the ending frame and is written first.
    - On an end pulse, the last written word has its `last` bit set, then the frame is resolved and the state returns to IDLE.
  - DROP: entered from IDLE or RECV when a write is needed while the buffer is full. Writes are suppressed. On an end pulse: `drop_count++`, `wr_ptr <= wr_commit`, return to IDLE. The verdict is ignored.
- **Resolve.**
  - Good verdict: `wr_commit <= wr_ptr` (including the final word), `good_count++`.
  - Bad verdict: `wr_ptr <= wr_commit`, `bad_count++`.
  - Both pulses asserted in the same cycle are treated as bad.
- **Read side.**
  - Registered RAM read followed by a one-entry output register (prefetch), so back-to-back words stream at one per cycle while `m_ready` is high.
  - `m_data`, `m_keep` and `m_last` are held stable while `m_valid && !m_ready`.
- **Reset.**
  - All pointers, counters and `m_valid` go to 0; state goes to SYNC.
  - A partial or committed-but-unread frame is lost.
  - `m_data`, `m_keep` and `m_last` reset to 0.

## Timing
- End pulse sampled at edge N: `wr_commit` is updated at N, and the first word is on `m_*` with `m_valid = 1` after edge N+2.
- Throughput: one word per cycle in and out. Reading and writing in the same cycle is legal, including when the buffer is full, because the full check uses the registered `rd_ptr`.
- Counters update on the edge that samples the end pulse.
- The write side never stalls the MAC (there is no backpressure). Loss happens only through DROP.

## Test plan
- **Good frame.** After reset and one idle cycle, send 3 words (valid FF, FF, 0F) with `rx_good_frame` on the third word, `m_ready = 1`. Required: 3 words out with keep FF, FF, 0F; `m_last` only on the third; first `m_valid` two cycles after the pulse; `good_count = 1`.
- **Bad frame then good frame.** Send a 4-word bad frame, then a 2-word good frame. Required: only the 2 good words appear; `bad_count = 1`, `good_count = 1`; no stale data is output.
- **Overflow.** `ADDR_W = 3`, `m_ready = 0`, send a 10-word good frame. Required: `drop_count = 1`, `good_count = 0`, `m_valid` stays 0. Then raise `m_ready` and send a 2-word good frame: it is output intact.
- **Backpressure.** Toggle `m_ready` pseudo-randomly over 20 frames of random length 1–20 words. Required: the output byte stream equals the input good frames exactly; outputs hold stable while stalled.
- **Mid-frame reset.** Assert `reset` for 1 cycle in the middle of frame A; the MAC finishes A with `rx_good_frame`, then sends good frame B. Required: A is not committed and no counter changes for it; B is output and `good_count = 1`.
- **Edge pulses.** A lone `rx_good_frame` with no data gives `drop_count = 1`. Simultaneous good and bad pulses on a 1-word frame give `bad_count = 1`, with no output.
